// File: rtl/regfile_dump_loader_if.sv
// Bus bundle for regfile_dump_loader: command channel, register-file
// read/write ports, dump output stream, load input stream and status.
//   master : the dump/load engine
//   slave  : the surrounding core / debug logic
interface regfile_dump_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_op_i;
  logic [ADDR_WIDTH-1:0] cmd_start_i;
  logic [ADDR_WIDTH-1:0] cmd_count_i;
  logic [ADDR_WIDTH-1:0] rf_rd_addr_o;
  logic [DATA_WIDTH-1:0] rf_rd_data_i;
  logic                  rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_wr_addr_o;
  logic [DATA_WIDTH-1:0] rf_wr_data_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic [ADDR_WIDTH-1:0] out_addr_o;
  logic                  out_last_o;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_start_i, cmd_count_i, rf_rd_data_i,
           out_ready_i, in_valid_i, in_data_i,
    output cmd_ready_o, rf_rd_addr_o, rf_we_o, rf_wr_addr_o, rf_wr_data_o,
           out_valid_o, out_data_o, out_addr_o, out_last_o, in_ready_o,
           busy_o, done_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_start_i, cmd_count_i, rf_rd_data_i,
           out_ready_i, in_valid_i, in_data_i,
    input  cmd_ready_o, rf_rd_addr_o, rf_we_o, rf_wr_addr_o, rf_wr_data_o,
           out_valid_o, out_data_o, out_addr_o, out_last_o, in_ready_o,
           busy_o, done_o
  );
endinterface

// File: rtl/regfile_dump_loader.sv
// regfile_dump_loader: debug/checkpoint engine for the integer register file.
// A command either streams a wrapping range of registers out (dump) or writes
// a range from an inbound stream into the register file (load).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - regfile_dump_loader_if.master (command, rf ports, streams, status)
module regfile_dump_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_dump_loader_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(REG_COUNT - 1);
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(REG_COUNT);
  localparam logic [ADDR_WIDTH:0]   ONE        = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, DUMP, LOAD, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  cmd_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic                  out_last_q;

  logic out_hs;
  logic in_hs;
  logic capture;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_IDX) ? '0 : a + 1'b1;
  endfunction

  always_comb begin
    out_hs  = out_valid_q && bus.out_ready_i;
    in_hs   = in_ready_q && bus.in_valid_i;
    // Refill the single output slot whenever it is empty or draining this edge.
    capture = (state == DUMP) && (remaining != '0) && (!out_valid_q || bus.out_ready_i);
  end

  assign bus.cmd_ready_o  = cmd_ready_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.in_ready_o   = in_ready_q;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_data_o   = out_data_q;
  assign bus.out_addr_o   = out_addr_q;
  assign bus.out_last_o   = out_last_q;
  assign bus.rf_rd_addr_o = (state == DUMP) ? cur_addr : '0;
  // x0 is hardwired: the beat is consumed but never written.
  assign bus.rf_we_o      = in_hs && (cur_addr != '0);
  assign bus.rf_wr_addr_o = cur_addr;
  assign bus.rf_wr_data_o = bus.in_data_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            cur_addr    <= bus.cmd_start_i;
            remaining   <= (bus.cmd_count_i == '0) ? FULL_COUNT : {1'b0, bus.cmd_count_i};
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.cmd_op_i) begin
              state      <= LOAD;
              in_ready_q <= 1'b1;
            end else begin
              state <= DUMP;
            end
          end
        end
        DUMP: begin
          if (capture) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.rf_rd_data_i;
            out_addr_q  <= cur_addr;
            out_last_q  <= (remaining == ONE);
            remaining   <= remaining - ONE;
            cur_addr    <= next_addr(cur_addr);
          end else if (out_hs) begin
            out_valid_q <= 1'b0;
          end
          // Nothing is left to capture once the last beat is in the slot,
          // so its handshake always leaves the slot empty.
          if (out_hs && out_last_q) begin
            state      <= DONE;
            done_q     <= 1'b1;
            out_last_q <= 1'b0;
          end
        end
        LOAD: begin
          if (in_hs) begin
            remaining <= remaining - ONE;
            cur_addr  <= next_addr(cur_addr);
            if (remaining == ONE) begin
              state      <= DONE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_loader.sv
module tb_regfile_dump_loader;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RC = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b0;
  logic auto_drive = 1'b0;

  regfile_dump_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_dump_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Register file seen by the DUT, and the model's idea of its contents.
  logic [DW-1:0] init_rf [RC];
  logic [DW-1:0] tb_rf   [RC];
  logic [DW-1:0] ref_rf  [RC];

  assign bus.rf_rd_data_i = (bus.rf_rd_addr_o == '0) ? '0 : tb_rf[bus.rf_rd_addr_o];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < RC; i++) tb_rf[i] <= init_rf[i];
    end else if (bus.rf_we_o) begin
      tb_rf[bus.rf_wr_addr_o] <= bus.rf_wr_data_o;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // mode: 0 idle, 1 dumping, 2 loading, 3 completion cycle
  int m_mode = 0;
  int m_start, m_n, m_k, m_age;
  int cur;
  bit exp_valid;
  bit exp_we;
  bit stall = 0;
  logic [DW-1:0] st_data;
  logic [AW-1:0] st_addr;
  logic          st_last;
  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  bit            obs_last[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (preload) for (int i = 0; i < RC; i++) ref_rf[i] = init_rf[i];
    if (rst) begin
      m_mode = 0;
      stall  = 0;
    end
    cur       = (m_start + m_k) % RC;
    exp_valid = (m_mode == 1) && (m_age >= 1) && (m_k < m_n);
    exp_we    = (m_mode == 2) && bus.in_valid_i && (cur != 0);
    chk("busy",      bus.busy_o,      m_mode != 0);
    chk("cmd_ready", bus.cmd_ready_o, m_mode == 0);
    chk("done",      bus.done_o,      m_mode == 3);
    chk("in_ready",  bus.in_ready_o,  m_mode == 2);
    chk("out_valid", bus.out_valid_o, exp_valid);
    chk("rf_we",     bus.rf_we_o,     exp_we);
    if (bus.done_o) done_cnt++;
    if (stall && !rst) begin
      chk("stall_valid", bus.out_valid_o, 1);
      chk("stall_data",  bus.out_data_o,  st_data);
      chk("stall_addr",  bus.out_addr_o,  st_addr);
      chk("stall_last",  bus.out_last_o,  st_last);
    end
    stall   = !rst && bus.out_valid_o && !bus.out_ready_i;
    st_data = bus.out_data_o;
    st_addr = bus.out_addr_o;
    st_last = bus.out_last_o;
    if (!rst) begin
      case (m_mode)
        0: if (bus.cmd_valid_i) begin
          m_start = int'(bus.cmd_start_i);
          m_n     = (bus.cmd_count_i == '0) ? RC : int'(bus.cmd_count_i);
          m_k     = 0;
          m_age   = 0;
          m_mode  = bus.cmd_op_i ? 2 : 1;
        end
        1: begin
          if (exp_valid && bus.out_ready_i) begin
            chk("beat_data", bus.out_data_o, ref_rf[cur]);
            chk("beat_addr", bus.out_addr_o, cur);
            chk("beat_last", bus.out_last_o, m_k == m_n - 1);
            obs_addr.push_back(bus.out_addr_o);
            obs_data.push_back(bus.out_data_o);
            obs_last.push_back(bus.out_last_o);
            m_k++;
            if (m_k == m_n) m_mode = 3;
          end
          m_age++;
        end
        2: if (bus.in_valid_i) begin
          if (cur != 0) begin
            chk("wr_addr", bus.rf_wr_addr_o, cur);
            chk("wr_data", bus.rf_wr_data_o, bus.in_data_i);
            ref_rf[cur] = bus.in_data_i;
          end
          m_k++;
          if (m_k == m_n) m_mode = 3;
        end
        default: m_mode = 0;
      endcase
    end
  end

  // Random stream traffic during the random phase.
  always @(posedge clk) begin
    #1;
    if (auto_drive) begin
      bus.out_ready_i = ($urandom_range(3) != 0);
      bus.in_valid_i  = ($urandom_range(2) != 0);
      bus.in_data_i   = $urandom;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic op, input logic [AW-1:0] start, input logic [AW-1:0] cnt);
    int t = 0;
    while (!bus.cmd_ready_o && t < 200) begin
      tick();
      t++;
    end
    chk("cmd_wait_timeout", t >= 200, 0);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_start_i = start;
    bus.cmd_count_i = cnt;
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (bus.busy_o && t < budget) begin
      tick();
      t++;
    end
    chk("idle_timeout", t >= budget, 0);
  endtask

  task automatic load_beat(input logic [DW-1:0] d);
    int t = 0;
    bus.in_data_i  = d;
    bus.in_valid_i = 1'b1;
    while (!bus.in_ready_o && t < 20) begin
      tick();
      t++;
    end
    chk("in_ready_timeout", t >= 20, 0);
    tick();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    obs_last.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp4 [4];
    logic [DW-1:0] old7;
    int lasts;
    int d0;

    for (int i = 0; i < RC; i++) init_rf[i] = $urandom;
    init_rf[0] = '0;
    init_rf[1] = 32'h11;
    init_rf[2] = 32'h22;
    init_rf[3] = 32'h33;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = 1'b0;
    bus.cmd_start_i = '0;
    bus.cmd_count_i = '0;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    preload = 1'b1;
    repeat (3) tick();
    preload = 1'b0;
    rst = 1'b0;
    tick();

    // Reset in the middle of a dump.
    bus.out_ready_i = 1'b1;
    issue(1'b0, 5'd0, 5'd8);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_busy",      bus.busy_o,      0);
    chk("rst_cmd_ready", bus.cmd_ready_o, 1);
    chk("rst_rf_we",     bus.rf_we_o,     0);
    tick();
    rst = 1'b0;
    tick();

    // Dump start=0 count=4, ready held high.
    exp4[0] = 32'h0; exp4[1] = 32'h11; exp4[2] = 32'h22; exp4[3] = 32'h33;
    clear_obs();
    d0 = done_cnt;
    issue(1'b0, 5'd0, 5'd4);
    wait_idle(100);
    chk("dump4_count", obs_addr.size(), 4);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      chk("dump4_addr", obs_addr[i], i);
      chk("dump4_data", obs_data[i], exp4[i]);
      chk("dump4_last", obs_last[i], i == 3);
    end
    chk("dump4_done_pulses", done_cnt - d0, 1);

    // Dump with a 3-cycle stall while beat addr 2 is presented.
    clear_obs();
    issue(1'b0, 5'd0, 5'd4);
    for (int t = 0; t < 20; t++) begin
      if (bus.out_valid_o && bus.out_addr_o == 5'd2) break;
      tick();
    end
    bus.out_ready_i = 1'b0;
    repeat (3) tick();
    chk("stall_hold_data", bus.out_data_o, 32'h22);
    chk("stall_hold_addr", bus.out_addr_o, 2);
    bus.out_ready_i = 1'b1;
    wait_idle(100);
    chk("stall_count", obs_addr.size(), 4);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) chk("stall_order", obs_addr[i], i);

    // Load start=30 count=4 wrapping through x0.
    d0 = done_cnt;
    issue(1'b1, 5'd30, 5'd4);
    load_beat(32'hA);
    load_beat(32'hB);
    load_beat(32'hC);
    load_beat(32'hD);
    wait_idle(100);
    chk("load_x30", tb_rf[30], 32'hA);
    chk("load_x31", tb_rf[31], 32'hB);
    chk("load_x0",  tb_rf[0],  32'h0);
    chk("load_x1",  tb_rf[1],  32'hD);
    chk("load_done_pulses", done_cnt - d0, 1);

    // Full-range dump (count 0 means all registers).
    clear_obs();
    issue(1'b0, 5'd0, 5'd0);
    wait_idle(200);
    chk("dump32_count", obs_addr.size(), 32);
    lasts = 0;
    foreach (obs_last[i]) if (obs_last[i]) lasts++;
    chk("dump32_lasts", lasts, 1);
    if (obs_addr.size() == 32) begin
      chk("dump32_addr31", obs_addr[31], 31);
      chk("dump32_last31", obs_last[31], 1);
      chk("dump32_x1",     obs_data[1],  32'hD);
    end

    // Reset after two beats of a three-beat load.
    old7 = tb_rf[7];
    d0 = done_cnt;
    issue(1'b1, 5'd5, 5'd3);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 32'h55;
    tick();
    bus.in_data_i  = 32'h66;
    tick();
    bus.in_data_i  = 32'h77;
    #2 rst = 1'b1;
    #1;
    chk("rstl_in_ready", bus.in_ready_o, 0);
    chk("rstl_rf_we",    bus.rf_we_o,    0);
    chk("rstl_busy",     bus.busy_o,     0);
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid_i = 1'b0;
    tick();
    chk("rstl_x5", tb_rf[5], 32'h55);
    chk("rstl_x6", tb_rf[6], 32'h66);
    chk("rstl_x7", tb_rf[7], old7);
    chk("rstl_no_done", done_cnt - d0, 0);
    clear_obs();
    issue(1'b0, 5'd5, 5'd2);
    wait_idle(100);
    chk("rstl_fresh_count", obs_data.size(), 2);
    if (obs_data.size() == 2) begin
      chk("rstl_fresh_x5", obs_data[0], 32'h55);
      chk("rstl_fresh_x6", obs_data[1], 32'h66);
    end

    // Random commands with random stream back-pressure.
    auto_drive = 1'b1;
    for (int n = 0; n < 30; n++) begin
      issue(1'($urandom_range(1)), 5'($urandom_range(31)), 5'($urandom_range(31)));
      wait_idle(400);
    end
    auto_drive = 1'b0;
    tick();
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < RC; i++) chk("final_rf", tb_rf[i], ref_rf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump_loader.md
# regfile_dump_loader

Debug/checkpoint engine that initiates bulk accesses to the integer register file. It streams a contiguous, wrapping range of registers out over a valid/ready interface (dump) or writes a range from an inbound valid/ready stream into the register file (load). It sits beside the decode stage and drives one register-file read address plus the write port while the core is held stalled by `busy_o`.

## Interface
- `DATA_WIDTH`, 32, register width (from `defines`)
- `ADDR_WIDTH`, 5, register index width (from `defines`)
- `REG_COUNT`, 32, number of registers (from `defines`)

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid_i`  in  1  command request
- `cmd_ready_o`  out  1  high in IDLE only
- `cmd_op_i`  in  1  0 = dump, 1 = load
- `cmd_start_i`  in  ADDR_WIDTH  first register index
- `cmd_count_i`  in  ADDR_WIDTH  register count; 0 encodes REG_COUNT
- `rf_rd_addr_o`  out  ADDR_WIDTH  register-file read address; read data returns combinationally
- `rf_rd_data_i`  in  DATA_WIDTH  register-file read data
- `rf_we_o`  out  1  register-file write enable
- `rf_wr_addr_o`  out  ADDR_WIDTH  write address
- `rf_wr_data_o`  out  DATA_WIDTH  write data
- `out_valid_o` / `out_ready_i`  out/in  1  dump stream handshake
- `out_data_o`  out  DATA_WIDTH  dumped value
- `out_addr_o`  out  ADDR_WIDTH  index of `out_data_o`
- `out_last_o`  out  1  final beat of the dump
- `in_valid_i` / `in_ready_o`  in/out  1  load stream handshake
- `in_data_i`  in  DATA_WIDTH  value to load
- `busy_o`  out  1  high in any state except IDLE
- `done_o`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DUMP, LOAD, DONE.
- IDLE: `cmd_ready_o`=1. `cmd_valid_i` is sampled on an edge with `rst` low. It latches the start index into `cur_addr` and the count (0 maps to REG_COUNT, held in an ADDR_WIDTH+1 counter), then moves to DUMP or LOAD per `cmd_op_i`.
- Addresses advance by 1 modulo REG_COUNT, so 31 wraps to 0.
- DUMP:
  - `rf_rd_addr_o`=`cur_addr`. There is a one-entry output register (data, addr, last).
  - Capture happens when `issue_remaining`>0 and (`!out_valid_o` or `out_ready_i`). On capture: load the output register, set `out_valid_o`, decrement `issue_remaining`, advance `cur_addr`.
  - `out_last_o`=1 on the beat captured when `issue_remaining`==1.
  - A handshake on the last beat goes to DONE.
  - While `out_valid_o`=1 and `out_ready_i`=0, data, addr and last stay stable.
  - x0 dumps as whatever the register file returns (0).
- LOAD:
  - `in_ready_o`=1.
  - On `in_valid_i`&&`in_ready_o`, in the same cycle: `rf_wr_addr_o`=`cur_addr`, `rf_wr_data_o`=`in_data_i`, and `rf_we_o`=1 unless `cur_addr`==0. A beat for x0 is consumed but not written.
  - Each beat decrements the remaining count and advances `cur_addr`. The last beat goes to DONE.
- DONE: `done_o`=1 for one cycle, then IDLE.
- `rf_we_o` is 0 outside LOAD handshakes. `rf_rd_addr_o` is don't-care outside DUMP and is driven to 0.

## Timing
- Reset (asynchronous, any state): state goes to IDLE. All counters, `out_valid_o`, `out_data_o`, `out_addr_o`, `out_last_o`, `rf_we_o`, `in_ready_o`, `busy_o` and `done_o` go to 0, and `cmd_ready_o`=1. Commands are ignored while `rst` is high.
- Reset mid-operation abandons the transfer. There are no further writes, a pending out beat is dropped, and no `done_o` is produced.
- Command accepted at edge T: `busy_o`=1 from T.
  - Dump: first capture at edge T+1, so first `out_valid_o` after T+1. With `out_ready_i` held high, N beats occupy N consecutive cycles, the last handshake is at edge T+N+1, and `done_o` is high in the following cycle.
  - Load: `in_ready_o`=1 from T. Writes commit at the register file on the handshake edge, 1 beat/cycle.
- After DONE, `cmd_ready_o`=1 in the next cycle. Minimum command-to-command spacing is N+3 cycles for a dump.
- `cmd_valid_i` outside IDLE is ignored (not queued).

## Test plan
- Reset: assert `rst` mid-cycle in DUMP -> immediately `out_valid_o`=0, `busy_o`=0, `cmd_ready_o`=1, `rf_we_o`=0.
- Dump, start=0, count=4, x1..x3=0x11,0x22,0x33, `out_ready_i`=1 -> beats (0,0),(1,0x11),(2,0x22),(3,0x33) on consecutive cycles. `out_last_o` is set only on addr 3, and `done_o` is a single pulse one cycle later.
- Dump with `out_ready_i` low for 3 cycles while beat addr 2 is valid -> `out_data_o`=0x22 and `out_addr_o`=2 stay stable. All 4 beats are delivered exactly once, in order.
- Load, start=30, count=4, data 0xA,0xB,0xC,0xD -> writes x30=0xA, x31=0xB, no `rf_we_o` for addr 0 (0xC consumed), x1=0xD, then `done_o`.
- Dump with count=0 -> 32 beats, addr 0..31, `out_last_o` only on the 32nd beat.
- Load with start=5, count=3; assert `rst` after 2 beats -> only x5,x6 written, third `in_valid_i` beat not accepted, `done_o` never pulses, and a fresh command is accepted afterwards.
